fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
- Sequences and shares the framebuffer write port (en_wr / addr_wr / din) between two requesters.
- Requester 1: a single-pixel stream (x, y, data) with valid/ready.
- Requester 2: a rectangle-fill command engine, which the block expands into per-pixel writes.
- Holds off all writes while the framebuffer's clear sequence is running (rst_busy); sits between drawing logic and framebuffer_with_reset.

Parameters:
- FRAME_WIDTH, 640, pixels per row.
- FRAME_HEIGHT, 480, rows per frame.
- COORD_WIDTH, 10, width of x/y/w/h fields; covers max(FRAME_WIDTH, FRAME_HEIGHT).
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2**ADDR_WIDTH >= FRAME_WIDTH*FRAME_HEIGHT.
- DATA_WIDTH, 8, pixel width.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- fb_rst_busy  in  1  framebuffer clear in progress; no writes issued while high.
- pix_valid  in  1  pixel request valid.
- pix_ready  out  1  pixel request accepted when pix_valid && pix_ready.
- pix_x, pix_y  in  COORD_WIDTH each  pixel coordinates.
- pix_data  in  DATA_WIDTH  pixel value.
- cmd_valid  in  1  fill command valid.
- cmd_ready  out  1  fill command accepted when cmd_valid && cmd_ready.
- cmd_x0, cmd_y0, cmd_w, cmd_h  in  COORD_WIDTH each  rectangle origin and size.
- cmd_color  in  DATA_WIDTH  fill value.
- fill_busy  out  1  high from command accept until the last fill write is issued.
- fill_done  out  1  one-cycle pulse on completion of a command.
- clip_err  out  1  one-cycle pulse when a pixel is dropped or a rectangle is clipped.
- fb_en_wr  out  1  framebuffer write enable.
- fb_addr_wr  out  ADDR_WIDTH  framebuffer write address.
- fb_din  out  DATA_WIDTH  framebuffer write data.

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = FILL, so the pixel port wins first contention.
- Address mapping: addr = y*FRAME_WIDTH + x, computed at full ADDR_WIDTH with no truncation.
- Write timing: all fb_* outputs are registered. A beat granted in cycle N drives fb_en_wr=1 in cycle N+1; fb_en_wr=0 in any cycle without a grant.
- FSM states: IDLE and FILL.
- cmd_ready = (state==IDLE) && !fb_rst_busy.
- On command accept:
  - Clip: x1 = min(x0+w, FRAME_WIDTH), y1 = min(y0+h, FRAME_HEIGHT); pulse clip_err if either bound is clipped.
  - If w==0, h==0, x0>=FRAME_WIDTH or y0>=FRAME_HEIGHT: no writes; fill_done pulses the next cycle; stay in IDLE.
  - Otherwise go to FILL with the cursor at (x0, y0) and fill_busy=1.
- FILL scan order: row-major, x first. A granted fill beat writes the cursor, then advances it: x+1, wrapping to x0 with y+1 at x1.
- Fill completion: on the beat at (x1-1, y1-1), fill_done pulses with that beat's fb_en_wr; state returns to IDLE; fill_busy=0 from the same cycle.
- pix_ready = !fb_rst_busy && !(state==FILL && last_grant==PIX). There is no combinational path from pix_valid.
- Arbitration:
  - Pixel alone: granted every cycle.
  - Fill alone: granted every cycle.
  - Both pending: grants alternate strictly (round-robin).
  - last_grant updates only on an actual grant.
- Out-of-range pixel (x>=FRAME_WIDTH or y>=FRAME_HEIGHT): accepted, no write, clip_err pulses; counts as a PIX grant.
- fb_rst_busy high: no grants; pix_ready=0 and cmd_ready=0. The fill cursor is frozen and resumes with no skipped or repeated addresses once fb_rst_busy falls.
- Async rst mid-fill: immediate return to reset state; the in-flight command is discarded.

Test Plan:
- FRAME 4x3, cmd (1,1,2,2,0xAA), no pixels -> fb_en_wr on 4 consecutive cycles, addr 5,6,9,10, data 0xAA; fill_done coincides with addr 10.
- Pixel (3,2,0x55) in IDLE -> pix_ready=1; one cycle later fb_en_wr=1, addr 11, din 0x55.
- cmd (0,0,4,3,0x11) plus continuous pixels at (0,0) -> write stream alternates PIX, FILL, PIX, ...; all 12 fill addresses 0..11 appear in order.
- cmd (2,1,5,5,0x22) -> clip_err pulse; writes at addr 6,7,10,11 only. Also: cmd with w=0 -> no writes, fill_done pulse; pixel (4,0) -> clip_err, no write.
- fb_rst_busy raised for 5 cycles after 2 of 6 fill beats -> fb_en_wr=0 and both ready signals 0 during the window; then remaining 4 addresses with no gap or duplicate.
- rst asserted mid-fill -> fb_en_wr, fill_busy and ready signals 0 immediately; after release, a new cmd is accepted in the first cycle.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Shares one framebuffer write port between a pixel stream and a rectangle-fill engine.
// Writes are registered (grant in cycle N -> fb_en_wr in N+1); everything stalls while fb_rst_busy is high.
module fb_write_scheduler #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int COORD_WIDTH  = 10,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fb_rst_busy,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [COORD_WIDTH-1:0] pix_x,
  input  logic [COORD_WIDTH-1:0] pix_y,
  input  logic [DATA_WIDTH-1:0]  pix_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_WIDTH-1:0] cmd_x0,
  input  logic [COORD_WIDTH-1:0] cmd_y0,
  input  logic [COORD_WIDTH-1:0] cmd_w,
  input  logic [COORD_WIDTH-1:0] cmd_h,
  input  logic [DATA_WIDTH-1:0]  cmd_color,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   clip_err,
  output logic                   fb_en_wr,
  output logic [ADDR_WIDTH-1:0]  fb_addr_wr,
  output logic [DATA_WIDTH-1:0]  fb_din
);

  typedef enum logic {IDLE, FILL} state_t;
  typedef enum logic {GNT_PIX, GNT_FILL} grant_t;

  localparam logic [COORD_WIDTH:0] FW = (COORD_WIDTH+1)'(FRAME_WIDTH);
  localparam logic [COORD_WIDTH:0] FH = (COORD_WIDTH+1)'(FRAME_HEIGHT);

  state_t                 state, state_nxt;
  grant_t                 last_grant;
  logic [COORD_WIDTH-1:0] cur_x, cur_y, org_x;
  logic [COORD_WIDTH:0]   end_x, end_y;
  logic [DATA_WIDTH-1:0]  fill_color;

  logic                   pix_grant, fill_grant, cmd_accept, pix_oor;
  logic [COORD_WIDTH:0]   sum_x, sum_y, step_x, step_y;
  logic                   clip_x, clip_y, cmd_empty, row_end, last_beat;
  logic [ADDR_WIDTH-1:0]  pix_addr, fill_addr;

  // Ready depends only on state and fb_rst_busy, never on the valids.
  assign cmd_ready  = !rst && !fb_rst_busy && (state == IDLE);
  assign pix_ready  = !rst && !fb_rst_busy && !((state == FILL) && (last_grant == GNT_PIX));
  assign pix_grant  = pix_valid && pix_ready;
  assign fill_grant = (state == FILL) && !fb_rst_busy && !pix_grant;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign fill_busy  = (state == FILL);

  assign pix_oor   = ({1'b0, pix_x} >= FW) || ({1'b0, pix_y} >= FH);
  assign sum_x     = {1'b0, cmd_x0} + {1'b0, cmd_w};
  assign sum_y     = {1'b0, cmd_y0} + {1'b0, cmd_h};
  assign clip_x    = sum_x > FW;
  assign clip_y    = sum_y > FH;
  assign cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                     ({1'b0, cmd_x0} >= FW) || ({1'b0, cmd_y0} >= FH);

  assign step_x    = {1'b0, cur_x} + (COORD_WIDTH+1)'(1);
  assign step_y    = {1'b0, cur_y} + (COORD_WIDTH+1)'(1);
  assign row_end   = (step_x == end_x);
  assign last_beat = row_end && (step_y == end_y);

  assign pix_addr  = ADDR_WIDTH'(pix_y) * ADDR_WIDTH'(FRAME_WIDTH) + ADDR_WIDTH'(pix_x);
  assign fill_addr = ADDR_WIDTH'(cur_y) * ADDR_WIDTH'(FRAME_WIDTH) + ADDR_WIDTH'(cur_x);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_accept && !cmd_empty) state_nxt = FILL;
      FILL:    if (fill_grant && last_beat)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_FILL;
      cur_x      <= '0;
      cur_y      <= '0;
      org_x      <= '0;
      end_x      <= '0;
      end_y      <= '0;
      fill_color <= '0;
      fb_en_wr   <= 1'b0;
      fb_addr_wr <= '0;
      fb_din     <= '0;
      fill_done  <= 1'b0;
      clip_err   <= 1'b0;
    end else begin
      if (pix_grant) begin
        last_grant <= GNT_PIX;
      end else if (fill_grant) begin
        last_grant <= GNT_FILL;
      end

      fb_en_wr <= (pix_grant && !pix_oor) || fill_grant;
      if (pix_grant && !pix_oor) begin
        fb_addr_wr <= pix_addr;
        fb_din     <= pix_data;
      end else if (fill_grant) begin
        fb_addr_wr <= fill_addr;
        fb_din     <= fill_color;
      end

      clip_err  <= (pix_grant && pix_oor) || (cmd_accept && (clip_x || clip_y));
      fill_done <= (cmd_accept && cmd_empty) || (fill_grant && last_beat);

      // Cursor only moves on a granted beat, so a clear pause resumes exactly where it stopped.
      if (cmd_accept) begin
        cur_x      <= cmd_x0;
        cur_y      <= cmd_y0;
        org_x      <= cmd_x0;
        end_x      <= clip_x ? FW : sum_x;
        end_y      <= clip_y ? FH : sum_y;
        fill_color <= cmd_color;
      end else if (fill_grant) begin
        if (row_end) begin
          cur_x <= org_x;
          cur_y <= step_y[COORD_WIDTH-1:0];
        end else begin
          cur_x <= step_x[COORD_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler on a 4x3 frame: directed scenarios plus a randomized
// run scored against a stream-level model of pixel and fill writes.
module tb_fb_write_scheduler;
  localparam int FW = 4;
  localparam int FH = 3;
  localparam int CW = 10;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fb_rst_busy = 1'b0;
  logic          pix_valid = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [CW-1:0] pix_x = '0, pix_y = '0;
  logic [DW-1:0] pix_data = '0;
  logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [DW-1:0] cmd_color = '0;
  logic          pix_ready, cmd_ready, fill_busy, fill_done, clip_err, fb_en_wr;
  logic [AW-1:0] fb_addr_wr;
  logic [DW-1:0] fb_din;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int clip_cnt = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  bit wr_done[$];
  bit wr_busy[$];

  fb_write_scheduler #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .COORD_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .fb_rst_busy(fb_rst_busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .fill_busy(fill_busy), .fill_done(fill_done), .clip_err(clip_err),
    .fb_en_wr(fb_en_wr), .fb_addr_wr(fb_addr_wr), .fb_din(fb_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_en_wr === 1'b1) begin
      wr_addr.push_back(int'(fb_addr_wr));
      wr_data.push_back(int'(fb_din));
      wr_cyc.push_back(cyc);
      wr_done.push_back(fill_done === 1'b1);
      wr_busy.push_back(fill_busy === 1'b1);
    end
    if (fill_done === 1'b1) done_cnt <= done_cnt + 1;
    if (clip_err === 1'b1) clip_cnt <= clip_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic issue_cmd(input int x0, input int y0, input int w, input int h, input int c,
                           output int acc);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_w = CW'(w); cmd_h = CW'(h); cmd_color = DW'(c);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    n_cmp++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b after 100 cycles, required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue_pix(input int x, input int y, input int d, output int acc);
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_x = CW'(x); pix_y = CW'(y); pix_data = DW'(d);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pix_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    n_cmp++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL pix_accept: pix_ready=%b after 100 cycles, required 1", pix_ready);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fill_busy === 1'b0) break;
    end
    n_cmp++;
    if (fill_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: fill_busy=%b, required 0", fill_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp += 8;
    if (fb_en_wr !== 1'b0)   begin n_fail++; $display("FAIL rst_en_wr: got %b, required 0", fb_en_wr); end
    if (fb_addr_wr !== '0)   begin n_fail++; $display("FAIL rst_addr: got %0d, required 0", fb_addr_wr); end
    if (fb_din !== '0)       begin n_fail++; $display("FAIL rst_din: got %0h, required 0", fb_din); end
    if (fill_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_fill_busy: got %b, required 0", fill_busy); end
    if (fill_done !== 1'b0)  begin n_fail++; $display("FAIL rst_fill_done: got %b, required 0", fill_done); end
    if (clip_err !== 1'b0)   begin n_fail++; $display("FAIL rst_clip_err: got %b, required 0", clip_err); end
    if (pix_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_pix_ready: got %b, required 0", pix_ready); end
    if (cmd_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_pix_ready: got %b, required 1", pix_ready); end
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready: got %b, required 1", cmd_ready); end
  endtask

  // Straight after reset the pixel port must win the first contention.
  task automatic test_first_contention;
    int acc;
    int b;
    b = wr_addr.size();
    issue_cmd(0, 0, 2, 1, 'h31, acc);
    pix_valid = 1'b1; pix_x = CW'(3); pix_y = CW'(2); pix_data = 8'h32;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_addr.size() - b >= 2) break;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (wr_addr.size() - b < 2) begin
      n_fail++; $display("FAIL contention_count: got %0d writes, required >=2", wr_addr.size() - b);
    end else begin
      n_cmp += 3;
      if (wr_data[b] !== 'h32)   begin n_fail++; $display("FAIL contention_first: got data %0h, required 32", wr_data[b]); end
      if (wr_addr[b] !== 11)     begin n_fail++; $display("FAIL contention_first_addr: got %0d, required 11", wr_addr[b]); end
      if (wr_data[b+1] !== 'h31) begin n_fail++; $display("FAIL contention_second: got data %0h, required 31", wr_data[b+1]); end
    end
  endtask

  task automatic test_fill_basic;
    int exp_a[4] = '{5, 6, 9, 10};
    int acc;
    int b;
    int d0;
    int c0;
    b = wr_addr.size(); d0 = done_cnt; c0 = clip_cnt;
    issue_cmd(1, 1, 2, 2, 'hAA, acc);
    wait_idle();
    n_cmp++;
    if (wr_addr.size() - b !== 4) begin
      n_fail++; $display("FAIL fill_count: got %0d writes, required 4", wr_addr.size() - b);
    end
    for (int i = 0; i < 4; i++) begin
      if (b + i < wr_addr.size()) begin
        n_cmp += 5;
        if (wr_addr[b+i] !== exp_a[i]) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d, required %0d", i, wr_addr[b+i], exp_a[i]); end
        if (wr_data[b+i] !== 'hAA)     begin n_fail++; $display("FAIL fill_data[%0d]: got %0h, required aa", i, wr_data[b+i]); end
        if (wr_cyc[b+i] !== acc + 2 + i) begin n_fail++; $display("FAIL fill_cycle[%0d]: got %0d, required %0d", i, wr_cyc[b+i], acc + 2 + i); end
        if (wr_done[b+i] !== (i == 3)) begin n_fail++; $display("FAIL fill_done_align[%0d]: got %b, required %b", i, wr_done[b+i], i == 3); end
        if (wr_busy[b+i] !== (i != 3)) begin n_fail++; $display("FAIL fill_busy[%0d]: got %b, required %b", i, wr_busy[b+i], i != 3); end
      end
    end
    n_cmp += 2;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL fill_done_count: got %0d, required 1", done_cnt - d0); end
    if (clip_cnt - c0 !== 0) begin n_fail++; $display("FAIL fill_clip_count: got %0d, required 0", clip_cnt - c0); end
  endtask

  task automatic test_pixel;
    int acc;
    issue_pix(3, 2, 'h55, acc);
    @(negedge clk);
    n_cmp += 3;
    if (fb_en_wr !== 1'b1)   begin n_fail++; $display("FAIL pix_en_wr: got %b, required 1", fb_en_wr); end
    if (fb_addr_wr !== 11)   begin n_fail++; $display("FAIL pix_addr: got %0d, required 11", fb_addr_wr); end
    if (fb_din !== 8'h55)    begin n_fail++; $display("FAIL pix_din: got %0h, required 55", fb_din); end
    @(negedge clk);
    n_cmp++;
    if (fb_en_wr !== 1'b0)   begin n_fail++; $display("FAIL pix_single: got en %b, required 0", fb_en_wr); end
  endtask

  task automatic test_round_robin;
    int b;
    int fi;
    b = wr_addr.size();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_x0 = '0; cmd_y0 = '0; cmd_w = CW'(4); cmd_h = CW'(3); cmd_color = 8'h11;
    pix_valid = 1'b1; pix_x = '0; pix_y = '0; pix_data = 8'h33;
    @(negedge clk);
    n_cmp += 2;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rr_cmd_ready: got %b, required 1", cmd_ready); end
    if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL rr_pix_ready: got %b, required 1", pix_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_addr.size() - b >= 24) break;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (wr_addr.size() - b < 24) begin
      n_fail++; $display("FAIL rr_count: got %0d writes, required >=24", wr_addr.size() - b);
    end else begin
      for (int i = 0; i < 24; i++) begin
        fi = i / 2;
        n_cmp += 4;
        if (wr_data[b+i] !== ((i % 2 == 0) ? 'h33 : 'h11)) begin
          n_fail++; $display("FAIL rr_order[%0d]: got data %0h, required %0h", i, wr_data[b+i], (i % 2 == 0) ? 'h33 : 'h11);
        end
        if (wr_addr[b+i] !== ((i % 2 == 0) ? 0 : fi)) begin
          n_fail++; $display("FAIL rr_addr[%0d]: got %0d, required %0d", i, wr_addr[b+i], (i % 2 == 0) ? 0 : fi);
        end
        if (wr_cyc[b+i] !== wr_cyc[b] + i) begin
          n_fail++; $display("FAIL rr_gap[%0d]: got cycle %0d, required %0d", i, wr_cyc[b+i], wr_cyc[b] + i);
        end
        if (wr_done[b+i] !== (i == 23)) begin
          n_fail++; $display("FAIL rr_done[%0d]: got %b, required %b", i, wr_done[b+i], i == 23);
        end
      end
    end
  endtask

  task automatic test_clip;
    int exp_a[4] = '{6, 7, 10, 11};
    int acc;
    int b;
    int c0;
    int d0;
    b = wr_addr.size(); c0 = clip_cnt; d0 = done_cnt;
    issue_cmd(2, 1, 5, 5, 'h22, acc);
    wait_idle();
    n_cmp += 3;
    if (clip_cnt - c0 !== 1)      begin n_fail++; $display("FAIL clip_pulse: got %0d pulses, required 1", clip_cnt - c0); end
    if (done_cnt - d0 !== 1)      begin n_fail++; $display("FAIL clip_done: got %0d pulses, required 1", done_cnt - d0); end
    if (wr_addr.size() - b !== 4) begin n_fail++; $display("FAIL clip_count: got %0d writes, required 4", wr_addr.size() - b); end
    for (int i = 0; i < 4; i++) begin
      if (b + i < wr_addr.size()) begin
        n_cmp++;
        if (wr_addr[b+i] !== exp_a[i]) begin n_fail++; $display("FAIL clip_addr[%0d]: got %0d, required %0d", i, wr_addr[b+i], exp_a[i]); end
      end
    end
    // Zero-width command: completes at once with no writes.
    b = wr_addr.size(); c0 = clip_cnt;
    issue_cmd(1, 1, 0, 2, 'h23, acc);
    @(negedge clk);
    n_cmp += 3;
    if (fill_done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b, required 1", fill_done); end
    if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b, required 0", fill_busy); end
    if (clip_err !== 1'b0)  begin n_fail++; $display("FAIL empty_clip: got %b, required 0", clip_err); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() - b !== 0) begin n_fail++; $display("FAIL empty_writes: got %0d, required 0", wr_addr.size() - b); end
    // Off-frame pixel is consumed without a write.
    issue_pix(4, 0, 'h24, acc);
    @(negedge clk);
    n_cmp += 2;
    if (clip_err !== 1'b1) begin n_fail++; $display("FAIL oor_clip: got %b, required 1", clip_err); end
    if (fb_en_wr !== 1'b0) begin n_fail++; $display("FAIL oor_write: got %b, required 0", fb_en_wr); end
  endtask

  task automatic test_rst_busy;
    int exp_a[6] = '{0, 1, 2, 4, 5, 6};
    int acc;
    int b;
    b = wr_addr.size();
    issue_cmd(0, 0, 3, 2, 'h44, acc);
    @(posedge clk);
    @(posedge clk); #1;
    fb_rst_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL busy_pix_ready[%0d]: got %b, required 0", i, pix_ready); end
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_cmd_ready[%0d]: got %b, required 0", i, cmd_ready); end
      if (i < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    fb_rst_busy = 1'b0;
    wait_idle();
    n_cmp++;
    if (wr_addr.size() - b !== 6) begin n_fail++; $display("FAIL busy_count: got %0d writes, required 6", wr_addr.size() - b); end
    for (int i = 0; i < 6; i++) begin
      if (b + i < wr_addr.size()) begin
        n_cmp += 2;
        if (wr_addr[b+i] !== exp_a[i]) begin n_fail++; $display("FAIL busy_addr[%0d]: got %0d, required %0d", i, wr_addr[b+i], exp_a[i]); end
        if (wr_cyc[b+i] !== acc + 2 + i + ((i >= 2) ? 5 : 0)) begin
          n_fail++; $display("FAIL busy_cycle[%0d]: got %0d, required %0d", i, wr_cyc[b+i], acc + 2 + i + ((i >= 2) ? 5 : 0));
        end
      end
    end
  endtask

  task automatic test_rst_mid_fill;
    int acc;
    int b;
    issue_cmd(0, 0, 4, 3, 'h66, acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp += 5;
    if (fb_en_wr !== 1'b0)  begin n_fail++; $display("FAIL arst_en_wr: got %b, required 0", fb_en_wr); end
    if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL arst_fill_busy: got %b, required 0", fill_busy); end
    if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL arst_pix_ready: got %b, required 0", pix_ready); end
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL arst_cmd_ready: got %b, required 0", cmd_ready); end
    if (fill_done !== 1'b0) begin n_fail++; $display("FAIL arst_fill_done: got %b, required 0", fill_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    b = wr_addr.size();
    cmd_valid = 1'b1; cmd_x0 = CW'(3); cmd_y0 = '0; cmd_w = CW'(1); cmd_h = CW'(1); cmd_color = 8'h77;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL arst_first_accept: cmd_ready=%b, required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (wr_addr.size() - b !== 1) begin
      n_fail++; $display("FAIL arst_new_count: got %0d writes, required 1", wr_addr.size() - b);
    end else begin
      n_cmp += 2;
      if (wr_addr[b] !== 3)    begin n_fail++; $display("FAIL arst_new_addr: got %0d, required 3", wr_addr[b]); end
      if (wr_data[b] !== 'h77) begin n_fail++; $display("FAIL arst_new_data: got %0h, required 77", wr_data[b]); end
    end
  endtask

  // Stream-level model: pixel writes follow accepted in-frame pixels in order, fill writes
  // follow the clipped row-major expansion of accepted commands, and pulse counts match events.
  task automatic test_random;
    int exp_pa[$], exp_pd[$], exp_fa[$], exp_fd[$];
    int got_pa[$], got_pd[$], got_fa[$], got_fd[$];
    int exp_clip;
    int exp_done;
    int b;
    int c0;
    int d0;
    int x1;
    int y1;
    int px, py, cx0, cy0, cw, ch;
    bit prev_busy;
    bit ev_clip;
    b = wr_addr.size(); c0 = clip_cnt; d0 = done_cnt;
    exp_clip = 0; exp_done = 0; prev_busy = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      pix_valid = ($urandom_range(0, 2) != 0);
      pix_x = CW'($urandom_range(0, 5)); pix_y = CW'($urandom_range(0, 4));
      pix_data = DW'($urandom_range(0, 127));
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_x0 = CW'($urandom_range(0, 5)); cmd_y0 = CW'($urandom_range(0, 4));
      cmd_w = CW'($urandom_range(0, 5));  cmd_h = CW'($urandom_range(0, 4));
      cmd_color = DW'(128 + $urandom_range(0, 127));
      fb_rst_busy = ($urandom_range(0, 11) == 0);
      @(negedge clk);
      if (prev_busy) begin
        n_cmp++;
        if (fb_en_wr !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_write: cycle %0d en=%b, required 0", cyc, fb_en_wr); end
      end
      if (fb_rst_busy) begin
        n_cmp += 2;
        if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_pix_ready: got %b, required 0", pix_ready); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_cmd_ready: got %b, required 0", cmd_ready); end
      end
      ev_clip = 1'b0;
      if (pix_valid && pix_ready === 1'b1) begin
        px = int'(pix_x); py = int'(pix_y);
        if (px < FW && py < FH) begin
          exp_pa.push_back(py * FW + px);
          exp_pd.push_back(int'(pix_data));
        end else begin
          ev_clip = 1'b1;
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        cx0 = int'(cmd_x0); cy0 = int'(cmd_y0); cw = int'(cmd_w); ch = int'(cmd_h);
        x1 = (cx0 + cw > FW) ? FW : cx0 + cw;
        y1 = (cy0 + ch > FH) ? FH : cy0 + ch;
        if (cx0 + cw > FW || cy0 + ch > FH) ev_clip = 1'b1;
        exp_done++;
        if (cw != 0 && ch != 0 && cx0 < FW && cy0 < FH) begin
          for (int yy = cy0; yy < y1; yy++) begin
            for (int xx = cx0; xx < x1; xx++) begin
              exp_fa.push_back(yy * FW + xx);
              exp_fd.push_back(int'(cmd_color));
            end
          end
        end
      end
      if (ev_clip) exp_clip++;
      prev_busy = fb_rst_busy;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; cmd_valid = 1'b0; fb_rst_busy = 1'b0;
    wait_idle();
    for (int i = b; i < wr_addr.size(); i++) begin
      if (wr_data[i] >= 128) begin
        got_fa.push_back(wr_addr[i]); got_fd.push_back(wr_data[i]);
      end else begin
        got_pa.push_back(wr_addr[i]); got_pd.push_back(wr_data[i]);
      end
    end
    n_cmp += 4;
    if (got_pa.size() !== exp_pa.size()) begin n_fail++; $display("FAIL rnd_pix_count: got %0d, required %0d", got_pa.size(), exp_pa.size()); end
    if (got_fa.size() !== exp_fa.size()) begin n_fail++; $display("FAIL rnd_fill_count: got %0d, required %0d", got_fa.size(), exp_fa.size()); end
    if (clip_cnt - c0 !== exp_clip) begin n_fail++; $display("FAIL rnd_clip_pulses: got %0d, required %0d", clip_cnt - c0, exp_clip); end
    if (done_cnt - d0 !== exp_done) begin n_fail++; $display("FAIL rnd_done_pulses: got %0d, required %0d", done_cnt - d0, exp_done); end
    for (int i = 0; i < got_pa.size() && i < exp_pa.size(); i++) begin
      n_cmp++;
      if (got_pa[i] !== exp_pa[i] || got_pd[i] !== exp_pd[i]) begin
        n_fail++; $display("FAIL rnd_pix[%0d]: got addr %0d data %0h, required addr %0d data %0h", i, got_pa[i], got_pd[i], exp_pa[i], exp_pd[i]);
      end
    end
    for (int i = 0; i < got_fa.size() && i < exp_fa.size(); i++) begin
      n_cmp++;
      if (got_fa[i] !== exp_fa[i] || got_fd[i] !== exp_fd[i]) begin
        n_fail++; $display("FAIL rnd_fill[%0d]: got addr %0d data %0h, required addr %0d data %0h", i, got_fa[i], got_fd[i], exp_fa[i], exp_fd[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_contention();
    test_fill_basic();
    test_pixel();
    test_round_robin();
    test_clip();
    test_rst_busy();
    test_rst_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
